// File: rtl/s4ga_pkg.sv
// Shared helpers and derived-size functions for the s4ga_stream LUT-network core.
package s4ga_pkg;

    localparam int unsigned DEF_N    = 71;
    localparam int unsigned DEF_K    = 5;
    localparam int unsigned DEF_I    = 2;
    localparam int unsigned DEF_O    = 7;
    localparam int unsigned DEF_SI_W = 4;

    // Ceiling log2, clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 32'd1;
        return r;
    endfunction

    // Ceiling division.
    function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
        return (a + b - 32'd1) / b;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a LUT index / LUT counter.
    function automatic int unsigned n_w(input int unsigned n);
        return clog2(n);
    endfunction

    // Width of the per-LUT field counter (0..K).
    function automatic int unsigned k_w(input int unsigned k);
        return clog2(k + 32'd1);
    endfunction

    function automatic int unsigned mask_w(input int unsigned k);
        return 32'd1 << k;
    endfunction

    function automatic int unsigned idx_segs(input int unsigned n, input int unsigned si_w);
        return cdiv(n_w(n), si_w);
    endfunction

    function automatic int unsigned mask_segs(input int unsigned k, input int unsigned si_w);
        return cdiv(mask_w(k), si_w);
    endfunction

    // Longest field in segments; sets the assembly register depth.
    function automatic int unsigned seg_max(input int unsigned n, input int unsigned k,
                                            input int unsigned si_w);
        return max2(idx_segs(n, si_w), mask_segs(k, si_w));
    endfunction

    // Segment counter width, never below one bit.
    function automatic int unsigned seg_w(input int unsigned n, input int unsigned k,
                                          input int unsigned si_w);
        return max2(32'd1, clog2(seg_max(n, k, si_w)));
    endfunction

    // Segments per LUT frame.
    function automatic int unsigned ll(input int unsigned n, input int unsigned k,
                                       input int unsigned si_w);
        return k * idx_segs(n, si_w) + mask_segs(k, si_w);
    endfunction

    // Special index codes: all-ones reads constant 1, all-ones-minus-1 reads q.
    function automatic int unsigned idx_one(input int unsigned nw);
        return (32'd1 << nw) - 32'd1;
    endfunction

    function automatic int unsigned idx_q(input int unsigned nw);
        return (32'd1 << nw) - 32'd2;
    endfunction

endpackage

// File: rtl/s4ga_seg_ctrl.sv
// Frame position tracking: LUT/field/segment counters, stall gating and SOF resync.
module s4ga_seg_ctrl
    import s4ga_pkg::*;
#(
    parameter  int unsigned N    = DEF_N,
    parameter  int unsigned K    = DEF_K,
    parameter  int unsigned SI_W = DEF_SI_W,
    localparam int unsigned N_W  = n_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           si_valid,
    input  logic           si_sof,
    output logic           idx_end_c,
    output logic           mask_end_c,
    output logic           frame_end_c,
    output logic           resync_c,
    output logic [N_W-1:0] n_c,
    output logic           sync_err
);

    localparam int unsigned K_W       = k_w(K);
    localparam int unsigned SEG_W     = seg_w(N, K, SI_W);
    localparam int unsigned IDX_SEGS  = idx_segs(N, SI_W);
    localparam int unsigned MASK_SEGS = mask_segs(K, SI_W);

    logic [N_W-1:0]   n, n_nxt;
    logic [K_W-1:0]   k, k_nxt, k_eff;
    logic [SEG_W-1:0] seg, seg_nxt, seg_eff;
    logic             sync_err_nxt;

    // Effective position of this beat (forced to 0/0/0 on misaligned SOF) and counter advance.
    always_comb begin
        resync_c     = 1'b0;
        n_c          = n;
        k_eff        = k;
        seg_eff      = seg;
        idx_end_c    = 1'b0;
        mask_end_c   = 1'b0;
        frame_end_c  = 1'b0;
        n_nxt        = n;
        k_nxt        = k;
        seg_nxt      = seg;
        sync_err_nxt = sync_err;

        resync_c = si_valid & si_sof & ((n != '0) | (k != '0) | (seg != '0));
        if (resync_c) begin
            n_c     = '0;
            k_eff   = '0;
            seg_eff = '0;
        end

        idx_end_c   = si_valid && (k_eff < K_W'(K)) && (seg_eff == SEG_W'(IDX_SEGS - 1));
        mask_end_c  = si_valid && (k_eff == K_W'(K)) && (seg_eff == SEG_W'(MASK_SEGS - 1));
        frame_end_c = mask_end_c && (n_c == N_W'(N - 1));
        sync_err_nxt = sync_err | resync_c;

        if (si_valid) begin
            if (mask_end_c) begin
                seg_nxt = '0;
                k_nxt   = '0;
                n_nxt   = frame_end_c ? '0 : n_c + 1'b1;
            end else if (idx_end_c) begin
                seg_nxt = '0;
                k_nxt   = k_eff + 1'b1;
                n_nxt   = n_c;
            end else begin
                seg_nxt = seg_eff + 1'b1;
                k_nxt   = k_eff;
                n_nxt   = n_c;
            end
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= '0;
            k        <= '0;
            seg      <= '0;
            sync_err <= 1'b0;
        end else begin
            n        <= n_nxt;
            k        <= k_nxt;
            seg      <= seg_nxt;
            sync_err <= sync_err_nxt;
        end
    end

endmodule

// File: rtl/s4ga_stream.sv
// Serially configured LUT-network core: assembles config fields, evaluates one LUT per frame
// slot into a recirculating LUT-output shift register and taps outputs at frame end.
module s4ga_stream
    import s4ga_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned K    = DEF_K,
    parameter int unsigned I    = DEF_I,
    parameter int unsigned O    = DEF_O,
    parameter int unsigned SI_W = DEF_SI_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SI_W-1:0] si,
    input  logic            si_valid,
    input  logic            si_sof,
    input  logic [I-1:0]    in_i,
    output logic [O-1:0]    out_o,
    output logic            out_valid,
    output logic            sync_err,
    output logic            dbg_o
);

    localparam int unsigned N_W     = n_w(N);
    localparam int unsigned MASK_W  = mask_w(K);
    localparam int unsigned SR_W    = seg_max(N, K, SI_W) * SI_W;
    localparam int unsigned SR_KEEP = SR_W - SI_W;
    localparam int unsigned LL      = ll(N, K, SI_W);
    localparam logic [N_W-1:0] IDX_ONE = N_W'(idx_one(N_W));
    localparam logic [N_W-1:0] IDX_Q   = N_W'(idx_q(N_W));

    logic              idx_end_c, mask_end_c, frame_end_c, resync_c;
    logic [N_W-1:0]    n_c;
    logic [SR_W-1:0]   field_c;
    logic [N_W-1:0]    idx_c;
    logic [MASK_W-1:0] mask_c;
    logic [N-1:0]      luts;
    logic [K-1:0]      ins, ins_base_c;
    logic              q;
    logic              in_bit_c, pass_c, lut_c;
    logic [O-1:0]      frame_out_c;

    s4ga_seg_ctrl #(
        .N    (N),
        .K    (K),
        .SI_W (SI_W)
    ) u_seg_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .si_valid    (si_valid),
        .si_sof      (si_sof),
        .idx_end_c   (idx_end_c),
        .mask_end_c  (mask_end_c),
        .frame_end_c (frame_end_c),
        .resync_c    (resync_c),
        .n_c         (n_c),
        .sync_err    (sync_err)
    );

    // Field assembly: older segments above the current one; single-segment fields need no history.
    if (SR_KEEP > 0) begin : g_sr
        logic [SR_KEEP-1:0] sr;

        // Segment history shifts only on accepted beats.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else if (si_valid) begin
                sr <= SR_KEEP'({sr, si});
            end
        end

        assign field_c = {sr, si};
    end else begin : g_nosr
        assign field_c = si;
    end

    assign idx_c  = field_c[N_W-1:0];
    assign mask_c = field_c[MASK_W-1:0];

    // Index decode, pass-through select and new LUT value.
    always_comb begin
        in_bit_c   = 1'b0;
        pass_c     = 1'b0;
        lut_c      = luts[N-1];
        ins_base_c = resync_c ? '0 : ins;

        if (idx_c == IDX_ONE) begin
            in_bit_c = 1'b1;
        end else if (idx_c == IDX_Q) begin
            in_bit_c = q;
        end else if (idx_c >= N_W'(N)) begin
            in_bit_c = 1'b0;
        end else begin
            in_bit_c = luts[idx_c];
        end

        for (int unsigned j = 0; j < I; j++) begin
            if (n_c == N_W'(j)) pass_c = in_i[j];
        end

        if (mask_end_c) begin
            lut_c = (n_c < N_W'(I)) ? pass_c : mask_c[ins];
        end
    end

    // Output taps: LUT N-1 is being written now; LUT N-1-i sits at a fixed register position.
    assign frame_out_c[0] = lut_c;
    for (genvar gi = 1; gi < O; gi++) begin : g_tap
        localparam int unsigned POS = (LL * gi - 1) % N;
        assign frame_out_c[gi] = luts[POS];
    end

    // LUT register, input collector, q, outputs and debug tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luts      <= '0;
            ins       <= '0;
            q         <= 1'b0;
            out_o     <= '0;
            out_valid <= 1'b0;
            dbg_o     <= 1'b0;
        end else begin
            out_valid <= frame_end_c;
            dbg_o     <= idx_end_c ? in_bit_c : (mask_end_c ? lut_c : 1'b0);
            if (si_valid) begin
                luts <= {luts[N-2:0], lut_c};
                ins  <= idx_end_c ? {ins_base_c[K-2:0], in_bit_c} : ins_base_c;
                if (mask_end_c) q <= mask_c[{1'b0, ins[K-2:0]}];
                if (frame_end_c) out_o <= frame_out_c;
            end
        end
    end

endmodule

// File: tb/tb_s4ga_stream.sv
// Directed bench for s4ga_stream with N=5, K=2, I=1, O=2, SI_W=4 (3 beats per LUT, 15 per frame).
// Index 0 on a LUT's first index beat addresses the previous LUT in the rotating register;
// index 7 is constant 1, index 6 is q, index 5 is out of range.
module tb_s4ga_stream;

    logic       clk;
    logic       rst_n;
    logic [3:0] si;
    logic       si_valid;
    logic       si_sof;
    logic [0:0] in_i;
    logic [1:0] out_o;
    logic       out_valid;
    logic       sync_err;
    logic       dbg_o;

    int n_checks;
    int n_fail;
    int lat;

    logic [3:0] fr        [15];
    logic       dbg_hist  [15];
    logic       serr_hist [15];

    s4ga_stream #(
        .N    (5),
        .K    (2),
        .I    (1),
        .O    (2),
        .SI_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .si        (si),
        .si_valid  (si_valid),
        .si_sof    (si_sof),
        .in_i      (in_i),
        .out_o     (out_o),
        .out_valid (out_valid),
        .sync_err  (sync_err),
        .dbg_o     (dbg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic v, input logic [3:0] s, input logic sof);
        si_valid = v;
        si       = s;
        si_sof   = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lut(input int n, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] m);
        fr[3*n]   = a;
        fr[3*n+1] = b;
        fr[3*n+2] = m;
    endtask

    // LUT0 passes in_i; LUTs 1..4 copy the previous LUT (idx {0, 7}, mask AND).
    task automatic chain_frame();
        set_lut(0, 4'd7, 4'd7, 4'd0);
        for (int n = 1; n < 5; n++) set_lut(n, 4'd0, 4'd7, 4'b1000);
    endtask

    // Streams nbeats of fr, optionally inserting stall_n idle cycles before beat stall_at.
    // lat is the cycle count at which out_valid first appears (0 if never).
    task automatic run_frame(input logic sof0, input int nbeats, input int stall_at,
                             input int stall_n, output int lat_o);
        int cyc;
        cyc   = 0;
        lat_o = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    step(1'b0, 4'hF, 1'b1);
                    cyc++;
                    check("stall_dbg", 32'(dbg_o), 32'd0);
                    if (out_valid === 1'b1 && lat_o == 0) lat_o = cyc;
                end
            end
            step(1'b1, fr[b], sof0 && (b == 0));
            cyc++;
            dbg_hist[b]  = dbg_o;
            serr_hist[b] = sync_err;
            if (out_valid === 1'b1 && lat_o == 0) lat_o = cyc;
        end
        si_valid = 1'b0;
        si_sof   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        si       = '0;
        si_valid = 1'b0;
        si_sof   = 1'b0;
        in_i     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_o", 32'(out_o), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_dbg", 32'(dbg_o), 32'd0);
        #3 rst_n = 1'b1;

        // Buffer chain, in_i=1.
        chain_frame();
        in_i = 1'b1;
        run_frame(1'b1, 15, -1, 0, lat);
        check("chain1_lat", 32'(lat), 32'd15);
        check("chain1_out", 32'(out_o), 32'd3);
        check("chain1_dbg14", 32'(dbg_hist[14]), 32'd1);
        check("chain1_serr", 32'(sync_err), 32'd0);
        step(1'b0, 4'd0, 1'b0);
        check("strobe_drop", 32'(out_valid), 32'd0);
        check("out_hold", 32'(out_o), 32'd3);
        check("idle_dbg", 32'(dbg_o), 32'd0);

        // Buffer chain, in_i=0.
        in_i = 1'b0;
        run_frame(1'b1, 15, -1, 0, lat);
        check("chain0_lat", 32'(lat), 32'd15);
        check("chain0_out", 32'(out_o), 32'd0);

        // Three stall cycles between LUT2's two index beats.
        in_i = 1'b1;
        run_frame(1'b1, 15, 7, 3, lat);
        check("stall_lat", 32'(lat), 32'd18);
        check("stall_out", 32'(out_o), 32'd3);

        // q path: LUT1=0 but q=1; LUT2 reads q; LUT3 copies LUT2; LUT4=0.
        in_i = 1'b0;
        set_lut(0, 4'd7, 4'd7, 4'd0);
        set_lut(1, 4'd7, 4'd7, 4'b0010);
        set_lut(2, 4'd6, 4'd7, 4'b1000);
        set_lut(3, 4'd0, 4'd7, 4'b1000);
        set_lut(4, 4'd7, 4'd7, 4'd0);
        run_frame(1'b1, 15, -1, 0, lat);
        check("q_lat", 32'(lat), 32'd15);
        check("q_out", 32'(out_o), 32'd2);
        check("q_dbg_lut1", 32'(dbg_hist[5]), 32'd0);
        check("q_dbg_idx", 32'(dbg_hist[6]), 32'd1);

        // Out-of-range index kills the chain at LUT1; LUT4 is constant 1.
        in_i = 1'b1;
        set_lut(0, 4'd7, 4'd7, 4'd0);
        set_lut(1, 4'd5, 4'd7, 4'b1000);
        set_lut(2, 4'd0, 4'd7, 4'b1000);
        set_lut(3, 4'd0, 4'd7, 4'b1000);
        set_lut(4, 4'd7, 4'd7, 4'b1000);
        run_frame(1'b1, 15, -1, 0, lat);
        check("oor_out", 32'(out_o), 32'd1);
        check("oor_dbg_idx5", 32'(dbg_hist[3]), 32'd0);
        check("oor_dbg_idx7", 32'(dbg_hist[4]), 32'd1);
        check("oor_serr", 32'(sync_err), 32'd0);

        // Misaligned SOF on beat 7 restarts the frame.
        chain_frame();
        in_i = 1'b1;
        run_frame(1'b1, 7, -1, 0, lat);
        check("partial_nv", 32'(lat), 32'd0);
        check("pre_resync_serr", 32'(sync_err), 32'd0);
        run_frame(1'b1, 15, -1, 0, lat);
        check("resync_serr_first", 32'(serr_hist[0]), 32'd1);
        check("resync_lat", 32'(lat), 32'd15);
        check("resync_out", 32'(out_o), 32'd3);
        check("resync_sticky", 32'(sync_err), 32'd1);

        // Asynchronous reset mid-frame, then a free-running frame without SOF.
        run_frame(1'b0, 5, -1, 0, lat);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_o", 32'(out_o), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_sync_err", 32'(sync_err), 32'd0);
        check("async_dbg", 32'(dbg_o), 32'd0);
        #3 rst_n = 1'b1;
        run_frame(1'b0, 15, -1, 0, lat);
        check("post_rst_lat", 32'(lat), 32'd15);
        check("post_rst_out", 32'(out_o), 32'd3);
        check("post_rst_serr", 32'(sync_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
